seg7_scan4: RTL

Four-digit time-multiplexed seven-segment display driver. Sits directly downstream of the arithmetic/switch logic: accepts a 16-bit value as four hex digits, decodes each to active-low segments and scans the digits one at a time onto the shared segment bus. New values are double-buffered and committed only at frame boundaries, so a digit is never shown half-updated.

---
 rtl/seg7_scan4.sv | 111 +++++++++++
 1 files changed

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous double buffering.
// Segments and enables are active-low; seg bit7 is the decimal point.
module seg7_scan4 #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] data,
   input  logic [3:0]  dp,
   input  logic        lz_blank,
   output logic [7:0]  seg,
   output logic [3:0]  en,
   output logic        pend,
   output logic        frame
);

   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       idx;
   logic [19:0]      disp;
   logic [19:0]      pending;
   logic             wrap_q;

   logic             tick;
   logic             wrap;
   logic             z3, z2, z1;
   logic [3:0]       blank;
   logic [3:0]       cur_digit;
   logic [3:0]       dp_bits;
   logic             cur_dp;
   logic [7:0]       seg_nxt;
   logic [3:0]       en_nxt;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      s = 7'h7F;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick = (div_cnt == DIV_LAST);
   assign wrap = tick && (idx == 2'd3);

   // A digit is a leading zero only if it and everything above it are zero.
   assign z3 = (disp[15:12] == 4'h0);
   assign z2 = z3 && (disp[11:8] == 4'h0);
   assign z1 = z2 && (disp[7:4] == 4'h0);

   assign dp_bits = disp[19:16];

   always_comb begin
      blank     = lz_blank ? {z3, z2, z1, 1'b0} : 4'b0000;
      cur_digit = disp[{idx, 2'b00} +: 4];
      cur_dp    = dp_bits[idx];
      seg_nxt   = blank[idx] ? {~cur_dp, 7'h7F} : {~cur_dp, hex_to_seg(cur_digit)};
      en_nxt    = ~(4'b0001 << idx);
   end

   // frame is delayed twice past the wrap so it lines up with digit 0's
   // first registered seg/en rather than with the idx change.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         idx     <= 2'd0;
         disp    <= 20'h0;
         pending <= 20'h0;
         pend    <= 1'b0;
         wrap_q  <= 1'b0;
         frame   <= 1'b0;
         seg     <= 8'hFF;
         en      <= 4'hF;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick)
            idx <= idx + 2'd1;
         if (wrap && pend)
            disp <= pending;
         if (load) begin
            pending <= {dp, data};
            pend    <= 1'b1;
         end else if (wrap) begin
            pend <= 1'b0;
         end
         wrap_q <= wrap;
         frame  <= wrap_q;
         seg    <= seg_nxt;
         en     <= en_nxt;
      end
   end

endmodule
